// File: rtl/fifo_rr_arbiter.sv
// Round-robin read scheduler: pops one flit at a time from NumPorts input FIFOs and presents it on a valid/ready output.
// Optional build macro ARB_LOCAL_PRIO_EN gives the local port (index NumPorts-1) absolute priority.
module fifo_rr_arbiter #(
   parameter int NumPorts      = 7,
   parameter int PortIdWidth   = 3,
   parameter int FlitWidth     = 82,
   parameter int ChildrenWidth = 3
) (
   input  logic                                            clk,
   input  logic                                            rst,
   input  logic [NumPorts-1:0]                             fifo_empty,
   input  logic [NumPorts*(FlitWidth+ChildrenWidth)-1:0]   fifo_data,
   output logic [NumPorts-1:0]                             rd_en,
   input  logic                                            out_ready,
   output logic                                            out_valid,
   output logic [FlitWidth+ChildrenWidth-1:0]              out_flit,
   output logic [PortIdWidth-1:0]                          grant_id,
   output logic                                            busy
);

   localparam int SlotWidth = FlitWidth + ChildrenWidth;
   localparam int NumSlots  = 1 << PortIdWidth;
   localparam int ValidBit  = FlitWidth - 1;
   localparam logic [PortIdWidth-1:0] LocalPort = PortIdWidth'(NumPorts - 1);

   typedef enum logic [1:0] {ARB, FETCH, SEND} state_t;

   state_t                 state;
   state_t                 state_next;
   logic [PortIdWidth-1:0] rr_ptr;
   logic [PortIdWidth-1:0] upper_idx;
   logic [PortIdWidth-1:0] lower_idx;
   logic                   upper_found;
   logic                   found;
   logic [PortIdWidth-1:0] winner;
   logic                   local_grant;
   logic [PortIdWidth-1:0] ptr_after_winner;
   logic [SlotWidth-1:0]   slot [NumSlots];
   logic [SlotWidth-1:0]   fetched;
   logic                   fetched_valid;

   // Unused slots are tied off so grant_id can index the full power-of-two range safely.
   for (genvar i = 0; i < NumSlots; i++) begin : g_slot
      if (i < NumPorts) begin : g_used
         assign slot[i] = fifo_data[i*SlotWidth +: SlotWidth];
      end else begin : g_pad
         assign slot[i] = '0;
      end
   end

   assign fetched       = slot[grant_id];
   assign fetched_valid = fetched[ValidBit];
   assign found         = (fifo_empty != '1);

   // Two-pass search: lowest non-empty port at or above rr_ptr, else lowest non-empty overall (the wrap).
   always_comb begin
      upper_found = 1'b0;
      upper_idx   = '0;
      lower_idx   = '0;
      for (int p = NumPorts - 1; p >= 0; p--) begin
         if (!fifo_empty[p]) begin
            lower_idx = PortIdWidth'(p);
            if (PortIdWidth'(p) >= rr_ptr) begin
               upper_found = 1'b1;
               upper_idx   = PortIdWidth'(p);
            end
         end
      end
   end

   always_comb begin
      winner      = upper_found ? upper_idx : lower_idx;
      local_grant = 1'b0;
`ifdef ARB_LOCAL_PRIO_EN
      if (!fifo_empty[NumPorts-1]) begin
         winner      = LocalPort;
         local_grant = 1'b1;
      end
`endif
   end

   assign ptr_after_winner = (winner == LocalPort) ? '0 : winner + PortIdWidth'(1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ARB;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ARB:     if (found) state_next = FETCH;
         FETCH:   state_next = fetched_valid ? SEND : ARB;
         SEND:    if (out_ready) state_next = ARB;
         default: state_next = ARB;
      endcase
   end

   always_comb begin
      rd_en = '0;
      for (int p = 0; p < NumPorts; p++) begin
         rd_en[p] = (state == ARB) && found && (winner == PortIdWidth'(p));
      end
      busy = (state != ARB);
   end

   // Local-priority grants leave rr_ptr alone so the remote ports keep their turn order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr    <= '0;
         grant_id  <= '0;
         out_flit  <= '0;
         out_valid <= 1'b0;
      end else begin
         if (state == ARB && found) begin
            grant_id <= winner;
            if (!local_grant) begin
               rr_ptr <= ptr_after_winner;
            end
         end
         if (state == FETCH && fetched_valid) begin
            out_flit  <= fetched;
            out_valid <= 1'b1;
         end
         if (state == SEND && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: models the input FIFOs (one-cycle registered read) and scoreboards delivered flits.
module tb_fifo_rr_arbiter;

   localparam int NumPorts      = 7;
   localparam int PortIdWidth   = 3;
   localparam int FlitWidth     = 82;
   localparam int ChildrenWidth = 3;
   localparam int SlotWidth     = FlitWidth + ChildrenWidth;

   typedef logic [SlotWidth-1:0] val_t;

   logic                          clk = 1'b0;
   logic                          rst;
   logic [NumPorts-1:0]           fifo_empty;
   logic [NumPorts*SlotWidth-1:0] fifo_data;
   logic [NumPorts-1:0]           rd_en;
   logic                          out_ready;
   logic                          out_valid;
   logic [SlotWidth-1:0]          out_flit;
   logic [PortIdWidth-1:0]        grant_id;
   logic                          busy;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   logic [SlotWidth-1:0]   fifo_q [NumPorts][$];
   logic [SlotWidth-1:0]   buf_out [NumPorts];
   logic [SlotWidth-1:0]   exp_flit_q [$];
   logic [PortIdWidth-1:0] exp_port_q [$];
   int                     grant_cycles [$];

   fifo_rr_arbiter #(
      .NumPorts(NumPorts),
      .PortIdWidth(PortIdWidth),
      .FlitWidth(FlitWidth),
      .ChildrenWidth(ChildrenWidth)
   ) dut (
      .clk(clk),
      .rst(rst),
      .fifo_empty(fifo_empty),
      .fifo_data(fifo_data),
      .rd_en(rd_en),
      .out_ready(out_ready),
      .out_valid(out_valid),
      .out_flit(out_flit),
      .grant_id(grant_id),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input val_t actual, input val_t expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
      end
   endtask

   task automatic refreshInputs();
      for (int p = 0; p < NumPorts; p++) begin
         fifo_empty[p] = (fifo_q[p].size() == 0);
         fifo_data[p*SlotWidth +: SlotWidth] = buf_out[p];
      end
   endtask

   function automatic val_t mkFlit(input logic vbit, input logic [31:0] payload);
      logic [48:0] mid;
      logic [2:0]  children;
      mid      = 49'({$urandom(), $urandom()});
      children = 3'($urandom_range(7, 0));
      return {children, vbit, mid, payload};
   endfunction

   // Loading a FIFO also queues the flit the DUT must later deliver (invalid flits are dropped by the DUT).
   task automatic applyStimulus(input int port, input val_t flit);
      fifo_q[port].push_back(flit);
      if (flit[FlitWidth-1]) begin
         exp_flit_q.push_back(flit);
         exp_port_q.push_back(PortIdWidth'(port));
      end
      refreshInputs();
   endtask

   function automatic bit anyPending();
      for (int p = 0; p < NumPorts; p++) begin
         if (fifo_q[p].size() != 0) return 1'b1;
      end
      return 1'b0;
   endfunction

   // One clock: monitor settled values just before the edge, then advance the FIFO model after it.
   task automatic tick();
      logic [NumPorts-1:0] rd_s;
      logic                rst_s;
      #1;
      rst_s = rst;
      rd_s  = rd_en;
      if (rst_s) begin
         if (rd_en != '0) begin
            checkOutput("rd_en_onehot", val_t'($onehot(rd_en)), val_t'(1));
            checkOutput("rd_en_target_nonempty", val_t'(rd_en & fifo_empty), val_t'(0));
            checkOutput("rd_en_only_in_arb", val_t'(busy), val_t'(0));
            grant_cycles.push_back(cycle);
         end
         if (out_valid && out_ready) begin
            checkOutput("sb_pending", val_t'(exp_flit_q.size() != 0), val_t'(1));
            if (exp_flit_q.size() != 0) begin
               checkOutput("sb_flit", out_flit, exp_flit_q.pop_front());
               checkOutput("sb_port", val_t'(grant_id), val_t'(exp_port_q.pop_front()));
            end
         end
      end
      @(posedge clk);
      #1;
      cycle++;
      if (!rst_s) begin
         for (int p = 0; p < NumPorts; p++) begin
            fifo_q[p].delete();
            buf_out[p] = '0;
         end
         exp_flit_q.delete();
         exp_port_q.delete();
      end else begin
         for (int p = 0; p < NumPorts; p++) begin
            if (rd_s[p] && fifo_q[p].size() != 0) buf_out[p] = fifo_q[p].pop_front();
         end
      end
      refreshInputs();
      @(negedge clk);
   endtask

   task automatic resetDut();
      rst       = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      grant_cycles.delete();
   endtask

   task automatic waitValid(input int maxCycles);
      int n;
      n = 0;
      while (!out_valid && n < maxCycles) begin
         tick();
         n++;
      end
      checkOutput("wait_out_valid", val_t'(out_valid), val_t'(1));
   endtask

   task automatic drainAll(input int maxCycles);
      int n;
      n = 0;
      out_ready = 1'b1;
      while ((exp_flit_q.size() != 0 || busy || anyPending()) && n < maxCycles) begin
         tick();
         n++;
      end
      checkOutput("drain_complete", val_t'(exp_flit_q.size()), val_t'(0));
   endtask

   initial begin
      val_t f_a;
      val_t f_b;

      rst       = 1'b0;
      out_ready = 1'b0;
      for (int p = 0; p < NumPorts; p++) buf_out[p] = '0;
      refreshInputs();

      resetDut();
      checkOutput("reset_out_valid", val_t'(out_valid), val_t'(0));
      checkOutput("reset_out_flit", out_flit, val_t'(0));
      checkOutput("reset_grant_id", val_t'(grant_id), val_t'(0));
      checkOutput("reset_rd_en", val_t'(rd_en), val_t'(0));
      checkOutput("reset_busy", val_t'(busy), val_t'(0));

      // Single request on port 2
      out_ready = 1'b1;
      applyStimulus(2, mkFlit(1'b1, 32'h0000_00A5));
      #1;
      checkOutput("single_rd_en", val_t'(rd_en), val_t'(7'b0000100));
      tick();
      checkOutput("single_rd_en_one_cycle", val_t'(rd_en), val_t'(0));
      checkOutput("single_fetch_busy", val_t'(busy), val_t'(1));
      tick();
      checkOutput("single_out_valid", val_t'(out_valid), val_t'(1));
      checkOutput("single_payload", val_t'(out_flit[31:0]), val_t'(32'h0000_00A5));
      checkOutput("single_grant_id", val_t'(grant_id), val_t'(2));
      drainAll(20);

      // All ports busy with out_ready high
      resetDut();
      out_ready = 1'b1;
`ifdef ARB_LOCAL_PRIO_EN
      for (int r = 0; r < 2; r++) applyStimulus(NumPorts - 1, mkFlit(1'b1, 32'(100 + r)));
      for (int r = 0; r < 2; r++) begin
         for (int p = 0; p < NumPorts - 1; p++) applyStimulus(p, mkFlit(1'b1, 32'(r * 16 + p)));
      end
`else
      for (int r = 0; r < 2; r++) begin
         for (int p = 0; p < NumPorts; p++) applyStimulus(p, mkFlit(1'b1, 32'(r * 16 + p)));
      end
`endif
      drainAll(200);
      checkOutput("all_grant_count", val_t'(grant_cycles.size()), val_t'(14));
      for (int i = 1; i < grant_cycles.size(); i++) begin
         checkOutput("all_grant_spacing", val_t'(grant_cycles[i] - grant_cycles[i-1]), val_t'(3));
      end

      // Backpressure held in SEND
      resetDut();
      f_a = mkFlit(1'b1, 32'h3333_0003);
      f_b = mkFlit(1'b1, 32'h4444_0004);
      applyStimulus(3, f_a);
      applyStimulus(4, f_b);
      out_ready = 1'b0;
      waitValid(10);
      for (int i = 0; i < 10; i++) begin
         checkOutput("bp_out_valid", val_t'(out_valid), val_t'(1));
         checkOutput("bp_out_flit", out_flit, f_a);
         checkOutput("bp_no_rd_en", val_t'(rd_en), val_t'(0));
         tick();
      end
      out_ready = 1'b1;
      tick();
      checkOutput("bp_release_arb", val_t'(busy), val_t'(0));
      checkOutput("bp_next_grant", val_t'(rd_en), val_t'(7'b0010000));
      drainAll(20);

      // Invalid flit is dropped, next requester granted
      resetDut();
      out_ready = 1'b1;
      applyStimulus(0, mkFlit(1'b0, 32'h0000_DEAD));
      applyStimulus(1, mkFlit(1'b1, 32'h0000_0011));
      #1;
      checkOutput("invalid_first_grant", val_t'(rd_en), val_t'(7'b0000001));
      tick();
      checkOutput("invalid_fetch_busy", val_t'(busy), val_t'(1));
      tick();
      checkOutput("invalid_no_valid", val_t'(out_valid), val_t'(0));
      checkOutput("invalid_back_to_arb", val_t'(busy), val_t'(0));
      checkOutput("invalid_out_flit_held", out_flit, val_t'(0));
      checkOutput("invalid_next_grant", val_t'(rd_en), val_t'(7'b0000010));
      drainAll(20);

      // Reset asserted while holding a flit in SEND
      resetDut();
      applyStimulus(3, mkFlit(1'b1, 32'h0000_5E4D));
      out_ready = 1'b0;
      waitValid(10);
      checkOutput("rst_pre_grant", val_t'(grant_id), val_t'(3));
      rst = 1'b0;
      tick();
      checkOutput("rst_out_valid", val_t'(out_valid), val_t'(0));
      checkOutput("rst_out_flit", out_flit, val_t'(0));
      checkOutput("rst_grant_id", val_t'(grant_id), val_t'(0));
      checkOutput("rst_busy", val_t'(busy), val_t'(0));
      rst = 1'b1;
      applyStimulus(2, mkFlit(1'b1, 32'h0000_0022));
      applyStimulus(5, mkFlit(1'b1, 32'h0000_0055));
      #1;
      checkOutput("rst_first_grant_lowest", val_t'(rd_en), val_t'(7'b0000100));
      drainAll(30);

      // Ports 1 and 6 contend with rr_ptr at 1
      resetDut();
      applyStimulus(0, mkFlit(1'b1, 32'h0000_0000));
      drainAll(20);
      f_a = mkFlit(1'b1, 32'h0000_0001);
      f_b = mkFlit(1'b1, 32'h0000_0006);
`ifdef ARB_LOCAL_PRIO_EN
      applyStimulus(6, f_b);
      applyStimulus(1, f_a);
      #1;
      checkOutput("prio_first_grant", val_t'(rd_en), val_t'(7'b1000000));
`else
      applyStimulus(1, f_a);
      applyStimulus(6, f_b);
      #1;
      checkOutput("prio_first_grant", val_t'(rd_en), val_t'(7'b0000010));
`endif
      drainAll(30);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

Round-robin read scheduler that shares one router output stage among `NumPorts` input flit FIFOs. It watches each FIFO's empty flag, pops one flit at a time from the winning FIFO, absorbs the FIFO's one-cycle registered read latency, and presents the flit on a valid/ready output. It sits between the per-port input FIFOs and the crossbar/reduction-table stage of the collective router.

## Interface

- `NumPorts`, 7, number of input FIFOs: 6 torus directions plus local injection; the local port is index `NumPorts-1`.
- `PortIdWidth`, 3, width of the port index; must satisfy 2^PortIdWidth >= NumPorts.
- `FlitWidth`, 82, flit width; bit 81 is the valid bit and bits 31:0 are the payload.
- `ChildrenWidth`, 3, width of the children field prepended inside the FIFOs.

- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  reset; one clock, reset is synchronous and active-low.
- `fifo_empty`  input  NumPorts  `buf_empty` of each FIFO; bit i belongs to port i.
- `fifo_data`  input  NumPorts*(FlitWidth+ChildrenWidth)  concatenated `buf_out` of each FIFO; port i occupies slice i.
- `rd_en`  output  NumPorts  one-hot read strobe to the FIFOs.
- `out_ready`  input  1  downstream can accept the flit this cycle.
- `out_valid`  output  1  `out_flit` holds a flit.
- `out_flit`  output  FlitWidth+ChildrenWidth  captured flit, including the children field.
- `grant_id`  output  PortIdWidth  source port of the flit being fetched or held.
- `busy`  output  1  high in FETCH and SEND.

## Operation

- FSM has three states: ARB, FETCH, SEND.
- **ARB**
  - The winner is the first port p with `fifo_empty[p]==0`, searching from `rr_ptr` upward and wrapping modulo NumPorts.
  - If a winner exists: `rd_en[p]=1` this cycle (combinational from state and `fifo_empty`); `grant_id<=p`; `rr_ptr<=(p+1) mod NumPorts`; next state FETCH.
  - If no winner exists: `rd_en=0` and the state stays ARB.
- **FETCH**
  - `rd_en=0`. The FIFO output `fifo_data[grant_id]` is now valid.
  - If bit 81 of the slice is 1: `out_flit<=slice`, `out_valid<=1`, next state SEND.
  - If bit 81 is 0: the flit is discarded, `out_flit` is unchanged, next state ARB.
- **SEND**
  - `out_valid=1`; `out_flit` and `grant_id` are held stable.
  - On `out_ready==1`: `out_valid<=0`, next state ARB.
  - Otherwise the state stays SEND indefinitely; there is no timeout.
- `rd_en` is never asserted outside ARB and is never multi-hot.
- `rd_en` never targets a port whose `fifo_empty` is 1.
- The `rr_ptr` wrap is explicit: p==NumPorts-1 gives `rr_ptr=0`. The pointer is never allowed to hold a value ≥ NumPorts.
- `busy = (state!=ARB)`.

## Timing

- Reset values: state ARB, `rr_ptr=0`, `out_valid=0`, `out_flit=0`, `grant_id=0`, `rd_en=0`, `busy=0`.
- Latency, with cycle N being ARB with a request present:
  - `rd_en` is high in N.
  - The flit is captured at the end of N+1.
  - `out_valid` is high from N+2.
- Best-case throughput is one flit per 3 cycles when `out_ready` is held high.
- The ARB→FETCH handoff relies on the FIFO updating `buf_out` on the same edge that samples `rd_en`.
- A port that empties between ARB and FETCH cannot occur: rd_en/pop is atomic in the FIFO.
- Reset asserted mid-operation:
  - Everything returns to reset values on the next edge.
  - A flit already popped and not yet delivered is lost. This is acceptable because the FIFOs are reset by the same signal.
- Simultaneous requests are resolved purely by `rr_ptr` order. Every continuously non-empty port is granted within NumPorts grants.
- `out_ready` is ignored outside SEND.

## Configuration

- `ARB_LOCAL_PRIO_EN` defined:
  - In ARB, if `fifo_empty[NumPorts-1]==0`, the local port wins regardless of `rr_ptr`.
  - `rr_ptr` is not updated on local-priority grants.
  - Other ports use round-robin only when the local FIFO is empty.
- `ARB_LOCAL_PRIO_EN` undefined: the local port is an ordinary round-robin participant.

## Test plan

- **Single request.** Reset, then `fifo_empty=7'b1111011` with port 2 holding flit bit81=1, payload 0x0000_00A5.
  - `rd_en=7'b0000100` for exactly one cycle.
  - Two cycles later: `out_valid=1`, `out_flit[31:0]=0xA5`, `grant_id=2`.
- **All ports busy, `out_ready=1`.** All 7 ports continuously non-empty.
  - Grants occur in order 0,1,2,3,4,5,6,0, one every 3 cycles.
  - `rd_en` is always one-hot.
- **Backpressure.** Hold `out_ready=0` for 10 cycles in SEND.
  - `out_valid` and `out_flit` stay stable.
  - No `rd_en` pulse occurs.
  - Raising `out_ready` returns the FSM to ARB on the next edge.
- **Invalid flit.** The captured flit has bit81=0.
  - `out_valid` stays 0 and the FSM returns to ARB after FETCH.
  - The next requester is granted.
- **Reset in SEND.** Drive `rst=0` while `out_valid=1`.
  - On the next edge: `out_valid=0`, `out_flit=0`, `grant_id=0`.
  - After release, the first grant goes to the lowest non-empty port.
- **Local priority** (`ARB_LOCAL_PRIO_EN`). Ports 1 and 6 both non-empty with `rr_ptr=1`.
  - Port 6 is granted first, then port 1.
  - Without the macro, port 1 is granted first.
